// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier.
// Operands are extended to WIDTH+1 bits (sign- or zero-extended by mode)
// so one recoding datapath serves both signed and unsigned products.
// One Booth step runs per cycle. The product register P only changes
// when an operation completes.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Widen an operand by one bit. The extra bit is a copy of the MSB in
  // signed mode and zero in unsigned mode, so both modes become signed
  // N-bit multiplies.
  function automatic logic [N-1:0] ext_op(input logic [WIDTH-1:0] v,
                                          input logic             sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  state_t                state_r;
  state_t                state_nx_s;
  logic [N-1:0]          acc_r;
  logic [N-1:0]          m_r;
  logic [N-1:0]          mc_r;
  logic                  q_r;
  logic [CW-1:0]         cnt_r;
  logic [2*WIDTH-1:0]    p_r;
  logic                  busy_r;
  logic                  done_r;

  logic [N-1:0]          sum_s;
  logic [N-1:0]          acc_shift_s;
  logic [N-1:0]          m_shift_s;
  logic [2*WIDTH-1:0]    prod_s;

  // Booth step: add/subtract/skip from {M[0],Q}, then arithmetic shift
  // of the {ACC, M} pair by one place.
  always_comb begin
    sum_s = acc_r;
    case ({m_r[0], q_r})
      2'b01:   sum_s = acc_r + mc_r;
      2'b10:   sum_s = acc_r - mc_r;
      default: sum_s = acc_r;
    endcase
    acc_shift_s = {sum_s[N-1], sum_s[N-1:1]};
    m_shift_s   = {sum_s[0], m_r[N-1:1]};
  end

  // Final product: the low 2*WIDTH bits of {ACC, M}. The two dropped
  // top bits only ever hold sign/zero extension.
  always_comb begin
    prod_s = {acc_r[N-3:0], m_r};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: IDLE waits for start, RUN counts N steps, FINISH
  // lasts a single cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_FINISH;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FINISH: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath and handshake registers: load on accepted start, step in
  // RUN, publish the product in FINISH. done is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= {N{1'b0}};
      m_r    <= {N{1'b0}};
      mc_r   <= {N{1'b0}};
      q_r    <= 1'b0;
      cnt_r  <= CNT_ZERO;
      p_r    <= {(2*WIDTH){1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mc_r   <= ext_op(A, signed_mode);
            m_r    <= ext_op(B, signed_mode);
            acc_r  <= {N{1'b0}};
            q_r    <= 1'b0;
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_r <= acc_shift_s;
          m_r   <= m_shift_s;
          q_r   <= m_r[0];
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_FINISH: begin
          p_r    <= prod_s;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign P    = p_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: an 8-bit and a 4-bit instance checked
// against an integer-arithmetic product model, plus handshake, latency
// and reset-abort scenarios.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic        start8, s8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start4, s4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int n_assert = 0;
  int n_fail   = 0;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(s8),
    .A(a8), .B(b8), .P(p8), .busy(busy8), .done(done8)
  );

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(s4),
    .A(a4), .B(b4), .P(p4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sgn);
    longint va, vb, mask;
    mask = (longint'(1) << w) - 1;
    va = longint'(a) & mask;
    vb = longint'(b) & mask;
    if (sgn && a[w-1]) va = va - (longint'(1) << w);
    if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
    return 64'((va * vb) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete operation on the selected instance, with latency, busy
  // duration, product and done-pulse width checks. Inputs are scrambled
  // right after the start edge to show they are not re-sampled.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input string tag);
    int   lat, bcnt;
    logic seen;
    logic [63:0] exp;
    exp = ref_mul(w, 32'(a), 32'(b), sgn);
    @(negedge clk);
    if (w == 8) begin
      a8 = a; b8 = b; s8 = sgn; start8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; s4 = sgn; start4 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((w == 8) ? busy8 : busy4) bcnt++;
      @(posedge clk); #1;
      lat++;
      if ((w == 8) ? done8 : done4) seen = 1'b1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(w + 2));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(w + 2));
    check({tag, " product"}, (w == 8) ? 64'(p8) : 64'(p4), exp);
    check({tag, " busy_at_done"}, (w == 8) ? 64'(busy8) : 64'(busy4), 64'd0);
    @(posedge clk); #1;
    check({tag, " done_width"}, (w == 8) ? 64'(done8) : 64'(done4), 64'd0);
  endtask

  initial begin : main
    int   lat, dcnt;
    logic held, seen;
    rst = 1'b1;
    start8 = 1'b0; s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start4 = 1'b0; s4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    #12;
    check("reset p8", 64'(p8), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset p4", 64'(p4), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed products, including the extreme operands.
    run_op(8, 8'd7,  8'hFD, 1'b1, "s7xm3");
    check("s7xm3 const", 64'(p8), 64'hFFEB);
    run_op(8, 8'h80, 8'h80, 1'b1, "smin_sq");
    check("smin_sq const", 64'(p8), 64'h4000);
    run_op(8, 8'hFF, 8'hFF, 1'b0, "umax_sq");
    check("umax_sq const", 64'(p8), 64'hFE01);
    run_op(8, 8'h80, 8'h02, 1'b0, "u80x2");
    check("u80x2 const", 64'(p8), 64'h0100);
    run_op(8, 8'h00, 8'h9B, 1'b1, "zero_a");
    run_op(8, 8'hC3, 8'h00, 1'b0, "zero_b");
    run_op(4, 8'h08, 8'h07, 1'b1, "w4 sm8x7");
    check("w4 sm8x7 const", 64'(p4), 64'hC8);
    run_op(4, 8'h0F, 8'h0F, 1'b0, "w4 umax_sq");
    check("w4 umax_sq const", 64'(p4), 64'hE1);

    // Randomised products on both widths.
    for (int i = 0; i < 12; i++) begin
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), "rand8");
      run_op(4, 8'($urandom), 8'($urandom), 1'($urandom), "rand4");
    end

    // Start while busy is ignored; then back-to-back start in done cycle.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6; s8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 4; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
    end
    check("ignored_start latency", 64'(lat), 64'd10);
    check("ignored_start product", 64'(p8), 64'd30);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; seen = 1'b0; held = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (p8 !== 16'd30) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
    end
    check("b2b p_held", 64'(held), 64'd1);
    check("b2b latency", 64'(lat), 64'd10);
    check("b2b product", 64'(p8), 64'h0001);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h7F; s8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort p8", 64'(p8), 64'd0);
    check("abort busy8", 64'(busy8), 64'd0);
    check("abort done8", 64'(done8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    check("abort no_done", 64'(dcnt), 64'd0);
    run_op(8, 8'd3, 8'd4, 1'b0, "after_abort");
    check("after_abort const", 64'(p8), 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake. It generalises the fixed 8-bit Booth datapath to any operand width and adds a signed/unsigned mode select. Operands are captured on start. One add/subtract-and-shift runs per cycle, and the result register holds until the next completed operation. It is intended as the reusable multiply engine for the ALU/datapath blocks in the same project.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a multiply; sampled only in IDLE
- signed_mode  input  1  1 = A and B are two's complement; 0 = A and B are unsigned; sampled with start
- A  input  WIDTH  multiplicand; sampled with start
- B  input  WIDTH  multiplier; sampled with start
- P  output  2*WIDTH  product register; updated only at completion
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when P has been updated

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, overrides everything):
  - state = IDLE, P = 0, busy = 0, done = 0.
  - Internal accumulator, Q bit and counter are all cleared.
- Internal width N = WIDTH+1.
  - Operands are extended to N bits: sign-extended if signed_mode=1, zero-extended if signed_mode=0.
  - This makes unsigned products correct with unchanged Booth recoding.
- Internal state:
  - Accumulator ACC (N bits).
  - Multiplier register M (N bits).
  - Residual bit Q.
  - Multiplicand register MC (N bits).
  - Counter CNT (ceil(log2(N+1)) bits).
- FSM has three states: IDLE, RUN, FINISH.
- IDLE:
  - If start=1 at a clock edge: MC <= ext(A), M <= ext(B), ACC <= 0, Q <= 0, CNT <= 0, busy <= 1, go to RUN.
  - If start=0: remain in IDLE.
- RUN: one Booth step per cycle, selected by {M[0],Q}:
  - 00 or 11: no add.
  - 01: ACC + MC.
  - 10: ACC - MC.
  - All arithmetic is modulo 2^N.
  - The {ACC', M} pair is then arithmetic-shifted right by 1, replicating ACC' MSB, and Q <= old M[0].
  - CNT increments; after N steps (CNT reaches N-1 on that step) go to FINISH.
- FINISH:
  - P <= low 2*WIDTH bits of {ACC, M}. The discarded top bits are always pure sign/zero extension.
  - done <= 1, busy <= 0, go to IDLE.
- Timing:
  - done is registered and high for exactly the one cycle after the FINISH edge, then returns to 0.
  - Latency: start sampled at edge k means P is valid and done=1 after edge k+N+1, i.e. WIDTH+2 edges.
  - busy is 1 from after edge k until after edge k+N+1.
- Handshake rules:
  - start while busy=1 is ignored with no effect on the current operation.
  - start asserted in the cycle done=1 is accepted, because the FSM is already in IDLE; back-to-back throughput is WIDTH+2 cycles per product.
  - A, B and signed_mode changing after the start edge have no effect on the current operation.
  - P holds the previous result throughout a new operation and changes only at FINISH.
- Reset asserted mid-operation aborts immediately: P = 0, busy = 0, no done pulse. After release the block is in IDLE and accepts start on the next edge.
- Edge operands must be exact for all inputs:
  - signed: most-negative x most-negative, for example -128*-128 = 16384 at WIDTH=8.
  - unsigned: all-ones x all-ones.
  - any operand 0 gives P = 0.

Test Plan:
- WIDTH=8, signed, A=7, B=-3 (0xFD) -> P=0xFFEB (-21), done pulses exactly 10 cycles after the start edge, busy high for 10 cycles.
- WIDTH=8, signed, A=B=0x80 -> P=0x4000; unsigned, A=B=0xFF -> P=0xFE01; unsigned A=0x80, B=0x02 -> P=0x0100.
- WIDTH=8, start A=5 B=6, then pulse start with A=9 B=9 while busy -> P=30, only one done pulse, second request ignored.
- Back-to-back: assert start again in the done cycle with A=-1 B=-1 signed -> second P=0x0001, done 10 cycles later; P holds 30 between the two done pulses.
- Reset mid-run: start A=0x7F B=0x7F, assert rst asynchronously (between edges) at cycle 4 -> P=0, busy=0 immediately, no done; after release, start A=3 B=4 -> P=12.
- WIDTH=4 instance: signed A=-8 (0x8) B=7 -> P=0xC8 (-56), latency 6 cycles; unsigned A=0xF B=0xF -> P=0xE1.
